sram_access_ctrl: RTL and testbench

// Multi-cycle data-memory controller behind the MEM stage.

---
 rtl/sram_access_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: turns one 32-bit MEM-stage load/store into two sequenced
// 16-bit SRAM accesses (low half, then high half), stalling the pipeline via
// ready_o while the access is in flight.
// Optional feature macro: SRAM_CTRL_RDBUF_EN (one-entry read buffer that lets
// a load of the most recently accessed word complete without SRAM activity).
module sram_access_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 3,
    parameter int BASE_ADDR   = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_r_en_i,
    input  logic              mem_w_en_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [15:0]       sram_wdata_o,
    input  logic [15:0]       sram_rdata_i,
    output logic              sram_we_n_o
);

    localparam int OFF_W = ADDR_W - 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [15:0]        wdata_hi_q, wdata_hi_d;
    logic               wr_q, wr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [ADDR_W-1:0]  sram_addr_q, sram_addr_d;
    logic [15:0]        sram_wdata_q, sram_wdata_d;
    logic               sram_we_n_q, sram_we_n_d;
    logic               req_s;
    logic [OFF_W-1:0]   off_s;

`ifdef SRAM_CTRL_RDBUF_EN
    logic [15:0]        wdata_lo_q, wdata_lo_d;
    logic               buf_vld_q, buf_vld_d;
    logic [OFF_W-1:0]   buf_off_q, buf_off_d;
    logic [31:0]        buf_data_q, buf_data_d;
`endif

    assign req_s = mem_r_en_i | mem_w_en_i;
    // Word offset relative to the SRAM window; truncation makes it wrap modulo the SRAM size.
    assign off_s = OFF_W'((addr_i - 32'(BASE_ADDR)) >> 2);

    assign ready_o      = ~req_s | (state_q == ST_DONE);
    assign rdata_o      = rdata_q;
    assign sram_addr_o  = sram_addr_q;
    assign sram_wdata_o = sram_wdata_q;
    assign sram_we_n_o  = sram_we_n_q;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            wdata_hi_q   <= 16'h0000;
            wr_q         <= 1'b0;
            rdata_q      <= 32'h0000_0000;
            sram_addr_q  <= '0;
            sram_wdata_q <= 16'h0000;
            sram_we_n_q  <= 1'b1;
`ifdef SRAM_CTRL_RDBUF_EN
            wdata_lo_q   <= 16'h0000;
            buf_vld_q    <= 1'b0;
            buf_off_q    <= '0;
            buf_data_q   <= 32'h0000_0000;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            wdata_hi_q   <= wdata_hi_d;
            wr_q         <= wr_d;
            rdata_q      <= rdata_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_we_n_q  <= sram_we_n_d;
`ifdef SRAM_CTRL_RDBUF_EN
            wdata_lo_q   <= wdata_lo_d;
            buf_vld_q    <= buf_vld_d;
            buf_off_q    <= buf_off_d;
            buf_data_q   <= buf_data_d;
`endif
        end
    end

    // Next-state and registered-output logic for the IDLE/LO/HI/DONE sequence.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        off_d        = off_q;
        wdata_hi_d   = wdata_hi_q;
        wr_d         = wr_q;
        rdata_d      = rdata_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        sram_we_n_d  = sram_we_n_q;
`ifdef SRAM_CTRL_RDBUF_EN
        wdata_lo_d   = wdata_lo_q;
        buf_vld_d    = buf_vld_q;
        buf_off_d    = buf_off_q;
        buf_data_d   = buf_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    off_d      = off_s;
                    wdata_hi_d = wdata_i[31:16];
                    wr_d       = mem_w_en_i;   // both enables high counts as a store
                    cnt_d      = '0;
`ifdef SRAM_CTRL_RDBUF_EN
                    wdata_lo_d = wdata_i[15:0];
                    if (!mem_w_en_i && buf_vld_q && (buf_off_q == off_s)) begin
                        // Buffer hit: answer from the buffer, leave the SRAM pins alone.
                        state_d = ST_DONE;
                        rdata_d = buf_data_q;
                    end else begin
                        state_d      = ST_LO;
                        sram_addr_d  = {off_s, 1'b0};
                        sram_wdata_d = wdata_i[15:0];
                        sram_we_n_d  = ~mem_w_en_i;
                    end
`else
                    state_d      = ST_LO;
                    sram_addr_d  = {off_s, 1'b0};
                    sram_wdata_d = wdata_i[15:0];
                    sram_we_n_d  = ~mem_w_en_i;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LO: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d        = '0;
                    state_d      = ST_HI;
                    sram_addr_d  = {off_q, 1'b1};
                    sram_wdata_d = wdata_hi_q;
                    if (!wr_q) begin
                        rdata_d[15:0] = sram_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HI: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                    sram_we_n_d = 1'b1;
                    if (!wr_q) begin
                        rdata_d[31:16] = sram_rdata_i;
                    end else begin
                        rdata_d = rdata_q;
                    end
`ifdef SRAM_CTRL_RDBUF_EN
                    buf_vld_d = 1'b1;
                    buf_off_d = off_q;
                    if (wr_q) begin
                        buf_data_d = {wdata_hi_q, wdata_lo_q};
                    end else begin
                        buf_data_d = {sram_rdata_i, rdata_q[15:0]};
                    end
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                // The pipeline advances here; a still-high request is a new instruction.
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                sram_we_n_d = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl with an SRAM model and an rdata scoreboard.
// Buffer-dependent expectations follow SRAM_CTRL_RDBUF_EN.
module tb_sram_access_ctrl;

    localparam int W = 3;
`ifdef SRAM_CTRL_RDBUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_r_en, mem_w_en;
    logic [31:0] addr, wdata, rdata;
    logic        ready;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_we_n;

    int checks = 0;
    int failures = 0;

    logic [15:0] sram [0:65535];
    logic [15:0] mm [int];
    logic [31:0] sb [$];
    logic [31:0] exp_rd = 32'h0;
    bit          bv = 1'b0;
    logic [14:0] boff = 15'h0;
    logic [31:0] bdata = 32'h0;
    logic [15:0] last_addr = 16'h0;

    always #5 clk = ~clk;

    sram_access_ctrl #(.ADDR_W(16), .WAIT_CYCLES(W), .BASE_ADDR(1024)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mem_r_en_i(mem_r_en), .mem_w_en_i(mem_w_en),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .ready_o(ready),
        .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata),
        .sram_rdata_i(sram_rdata), .sram_we_n_o(sram_we_n)
    );

    assign sram_rdata = sram[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n) sram[sram_addr] <= sram_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        logic [14:0] off;
        bit hit, done;
        int lat;
        off = 15'((a - 32'd1024) >> 2);
        hit = BUF_EN && rd && !wr && bv && (boff == off);
        lat = hit ? 1 : 2 * W + 1;
        if (wr) begin
            mm[int'({off, 1'b0})] = d[15:0];
            mm[int'({off, 1'b1})] = d[31:16];
        end else begin
            exp_rd = hit ? bdata : {mm[int'({off, 1'b1})], mm[int'({off, 1'b0})]};
        end
        sb.push_back(exp_rd);
        @(negedge clk);
        mem_r_en = rd; mem_w_en = wr; addr = a; wdata = d;
        #1;
        chk("ready_cycle0", {31'h0, ready}, 32'h0);
        done = 1'b0;
        for (int c = 1; c <= 20 && !done; c++) begin
            @(posedge clk); #1;
            if (!hit && c <= 2 * W) begin
                chk("ready_busy", {31'h0, ready}, 32'h0);
                chk("sram_addr_phase", {16'h0, sram_addr}, {16'h0, off, (c > W) ? 1'b1 : 1'b0});
                chk("sram_wdata_phase", {16'h0, sram_wdata}, {16'h0, (c > W) ? d[31:16] : d[15:0]});
                chk("sram_we_n_phase", {31'h0, sram_we_n}, {31'h0, ~wr});
            end
            if (ready) begin
                done = 1'b1;
                chk("latency", c, lat);
                chk("we_n_done", {31'h0, sram_we_n}, 32'h1);
                chk("sram_addr_done", {16'h0, sram_addr}, {16'h0, hit ? last_addr : {off, 1'b1}});
                chk("rdata", rdata, sb.pop_front());
            end
        end
        checks++;
        assert (done) else begin
            failures++;
            $error("FAIL timeout observed=busy expected=ready");
        end
        if (!hit) last_addr = {off, 1'b1};
        bv = 1'b1;
        boff = off;
        bdata = wr ? d : exp_rd;
        @(negedge clk);
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_sram_addr", {16'h0, sram_addr}, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'h0);
        access(1'b0, 1'b1, 32'd1032, 32'hA5A55A5A);
        access(1'b0, 1'b1, 32'd1028, 32'h12345678);
        access(1'b1, 1'b0, 32'd1028, 32'h0);
        access(1'b1, 1'b0, 32'd1032, 32'h0);
        access(1'b1, 1'b1, 32'd1036, 32'h0BADF00D);
        access(1'b1, 1'b0, 32'd1036, 32'h0);
        access(1'b0, 1'b1, 32'd1020, 32'h11223344);
        access(1'b1, 1'b0, 32'd1020, 32'h0);

        // Reset in the first HI cycle of a store aborts it.
        @(negedge clk);
        mem_w_en = 1'b1; addr = 32'd1040; wdata = 32'hCAFEF00D;
        repeat (4) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_we_n", {31'h0, sram_we_n}, 32'h1);
        chk("abort_sram_addr", {16'h0, sram_addr}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_ready_req", {31'h0, ready}, 32'h0);
        mem_w_en = 1'b0; #1;
        chk("abort_ready_idle", {31'h0, ready}, 32'h1);
        @(negedge clk); rst_n = 1'b1;
        exp_rd = 32'h0; bv = 1'b0; last_addr = 16'h0;
        @(posedge clk);
        access(1'b0, 1'b1, 32'd1040, 32'hCAFEF00D);
        access(1'b1, 1'b0, 32'd1040, 32'h0);
        access(1'b1, 1'b0, 32'd1024, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
